// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the PC reset value.
// Imported by the fetch controller, the hazard unit and the testbench.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DROP  = 3'd4
  } fetch_state_e;

  localparam int unsigned PC_RESET = 0;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port: single-outstanding request strobe plus response.
// The fetch controller is the master; the memory is the slave.
interface fetch_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 5
) ();

  logic               imem_req;
  logic [PC_BITS-1:0] imem_addr;
  logic               imem_rvalid;
  logic [XLEN-1:0]    imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, issues one instruction-memory
// request at a time, holds the returned instruction for the F/D register,
// and handles decode stalls, redirects and stale-response discard.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_ctrl_if.master       imem,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_BITS-1:0] redirect_pc_i,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_valid,
  output logic               fd_en,
  output logic               fd_flush
);

  fetch_state_e       state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] pc_plus1;
  logic [PC_BITS-1:0] f_pc_d;
  logic [XLEN-1:0]    f_inst_d;
  logic               f_valid_d;

  // Wraps modulo 2^PC_BITS by plain truncation; no overflow flag.
  assign pc_plus1 = pc_q + PC_BITS'(1);

  // The held instruction is consumed whenever decode accepts it and no flush
  // is in progress; a redirect turns the F/D register into a bubble instead.
  assign fd_en    = F_valid & ~stall_i & ~redirect_i;
  assign fd_flush = redirect_i & (state_q != IDLE);

  // Next-state, next-datapath and memory-request decode.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    f_pc_d         = F_pc;
    f_inst_d       = F_inst;
    f_valid_d      = F_valid;
    imem.imem_req  = 1'b0;
    imem.imem_addr = '0;

    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        if (redirect_i) begin
          // Suppress this cycle's request and retry at the new PC.
          pc_d    = redirect_pc_i;
          state_d = FETCH;
        end else begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = pc_q;
          state_d        = WAIT;
        end
      end

      WAIT: begin
        if (redirect_i) begin
          // A response already arriving is simply dropped; otherwise the
          // in-flight one must be swallowed in DROP before refetching.
          pc_d      = redirect_pc_i;
          f_valid_d = 1'b0;
          state_d   = imem.imem_rvalid ? FETCH : DROP;
        end else if (imem.imem_rvalid) begin
          f_inst_d  = imem.imem_rdata;
          f_pc_d    = pc_q;
          f_valid_d = 1'b1;
          state_d   = VALID;
        end
      end

      VALID: begin
        if (redirect_i) begin
          pc_d      = redirect_pc_i;
          f_valid_d = 1'b0;
          state_d   = FETCH;
        end else if (!stall_i) begin
          // Consumed this cycle: request the successor immediately.
          pc_d           = pc_plus1;
          f_valid_d      = 1'b0;
          imem.imem_req  = 1'b1;
          imem.imem_addr = pc_plus1;
          state_d        = WAIT;
        end
      end

      DROP: begin
        if (redirect_i) begin
          pc_d = redirect_pc_i;
        end
        if (imem.imem_rvalid) begin
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and F/D-facing instruction holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_BITS'(PC_RESET);
      F_pc    <= '0;
      F_inst  <= '0;
      F_valid <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      F_pc    <= f_pc_d;
      F_inst  <= f_inst_d;
      F_valid <= f_valid_d;
    end
  end

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus pushes expected memory
// requests and F/D consumptions into queues; a monitor pops and compares.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int XLEN    = 32;
  localparam int PC_BITS = 5;

  typedef struct {
    logic [PC_BITS-1:0] pc;
    logic [XLEN-1:0]    inst;
  } fd_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               stall_i = 1'b0;
  logic               redirect_i = 1'b0;
  logic [PC_BITS-1:0] redirect_pc_i = '0;
  logic [PC_BITS-1:0] F_pc;
  logic [XLEN-1:0]    F_inst;
  logic               F_valid;
  logic               fd_en;
  logic               fd_flush;

  int checks = 0;
  int failures = 0;
  int mem_lat = 1;

  logic [PC_BITS-1:0] exp_addr[$];
  fd_t                exp_fd[$];

  fetch_ctrl_if #(.XLEN(XLEN), .PC_BITS(PC_BITS)) ifc ();

  fetch_ctrl #(.XLEN(XLEN), .PC_BITS(PC_BITS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (ifc.master),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .F_pc          (F_pc),
    .F_inst        (F_inst),
    .F_valid       (F_valid),
    .fd_en         (fd_en),
    .fd_flush      (fd_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_fd(input logic [PC_BITS-1:0] pc, input logic [XLEN-1:0] inst);
    fd_t e;
    e.pc   = pc;
    e.inst = inst;
    exp_fd.push_back(e);
  endtask

  // Memory model: answers each request after mem_lat cycles with 0x100+addr.
  initial begin
    int                 cnt;
    logic               pend;
    logic [PC_BITS-1:0] paddr;
    cnt   = 0;
    pend  = 1'b0;
    paddr = '0;
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      ifc.imem_rvalid = 1'b0;
      ifc.imem_rdata  = '0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt <= 1) begin
          ifc.imem_rvalid = 1'b1;
          ifc.imem_rdata  = 32'h100 + XLEN'(paddr);
          pend            = 1'b0;
        end else begin
          cnt--;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        pend            = 1'b0;
        ifc.imem_rvalid = 1'b0;
      end else if (ifc.imem_req) begin
        pend  = 1'b1;
        paddr = ifc.imem_addr;
        cnt   = mem_lat;
      end
    end
  end

  // Monitor: compares every issued request and every F/D consumption.
  initial begin
    fd_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifc.imem_req) begin
          if (exp_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: got addr 0x%0h expected none at %0t", ifc.imem_addr, $time);
          end else begin
            check("req_addr", 64'(ifc.imem_addr), 64'(exp_addr.pop_front()));
          end
        end
        if (fd_en) begin
          if (exp_fd.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_fd_en: got pc 0x%0h expected none at %0t", F_pc, $time);
          end else begin
            e = exp_fd.pop_front();
            check("fd_pc", 64'(F_pc), 64'(e.pc));
            check("fd_inst", 64'(F_inst), 64'(e.inst));
          end
        end
      end
    end
  end

  // Directed stimulus and cycle-exact checks.
  initial begin
    bit exp_fv [7];
    bit exp_req[7];
    logic [PC_BITS-1:0] pc0;
    exp_fv  = '{0, 0, 0, 1, 0, 1, 0};
    exp_req = '{0, 1, 0, 1, 0, 1, 0};
    pc0     = PC_BITS'(PC_RESET);

    // Expected request stream, including wrap 31 -> 0 and the post-reset restart.
    foreach (exp_addr[i]) exp_addr.delete(i);
    exp_addr.push_back(pc0);
    exp_addr.push_back(5'd1);
    exp_addr.push_back(5'd2);
    exp_addr.push_back(5'd3);
    exp_addr.push_back(5'h10);
    exp_addr.push_back(5'h11);
    exp_addr.push_back(5'd30);
    exp_addr.push_back(5'd31);
    exp_addr.push_back(5'd0);
    exp_addr.push_back(5'd1);
    exp_addr.push_back(5'd2);
    exp_addr.push_back(pc0);
    exp_addr.push_back(5'd1);
    exp_addr.push_back(5'd2);

    // Expected consumptions: stale 0x103 and the redirected 0x11 never appear.
    push_fd(5'd0,  32'h100);
    push_fd(5'd1,  32'h101);
    push_fd(5'd2,  32'h102);
    push_fd(5'h10, 32'h110);
    push_fd(5'd30, 32'h11E);
    push_fd(5'd31, 32'h11F);
    push_fd(5'd0,  32'h100);
    push_fd(5'd1,  32'h101);
    push_fd(5'd0,  32'h100);
    push_fd(5'd1,  32'h101);

    // Reset state, with a redirect attempt that must not leak through.
    redirect_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 64'(ifc.imem_req), 64'd0);
    check("rst_fd_flush", 64'(fd_flush), 64'd0);
    check("rst_F_valid", 64'(F_valid), 64'd0);
    check("rst_F_inst", 64'(F_inst), 64'd0);
    redirect_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Free run: F_valid and fd_en at cycles 3 and 5.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("run_F_valid_c%0d", k), 64'(F_valid), 64'(exp_fv[k]));
      check($sformatf("run_fd_en_c%0d", k), 64'(fd_en), 64'(exp_fv[k]));
      check($sformatf("run_req_c%0d", k), 64'(ifc.imem_req), 64'(exp_req[k]));
      cyc(1);
    end

    // Cycle 7: VALID at pc=2, stall for four cycles.
    stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_F_valid", 64'(F_valid), 64'd1);
      check("stall_F_pc", 64'(F_pc), 64'd2);
      check("stall_F_inst", 64'(F_inst), 64'h102);
      check("stall_req", 64'(ifc.imem_req), 64'd0);
      check("stall_fd_en", 64'(fd_en), 64'd0);
      cyc(1);
    end

    // Cycle 11: release; next request (addr 3) answered two cycles later.
    stall_i = 1'b0;
    mem_lat = 2;
    @(negedge clk);
    check("release_fd_en", 64'(fd_en), 64'd1);
    check("release_addr", 64'(ifc.imem_addr), 64'd3);
    cyc(1);

    // Cycle 12: redirect while WAIT with the response still outstanding.
    redirect_i    = 1'b1;
    redirect_pc_i = 5'h10;
    @(negedge clk);
    check("redir_fd_flush", 64'(fd_flush), 64'd1);
    check("redir_req", 64'(ifc.imem_req), 64'd0);
    cyc(1);

    // Cycle 13: DROP swallows the stale response.
    redirect_i = 1'b0;
    mem_lat    = 1;
    @(negedge clk);
    check("drop_fd_flush", 64'(fd_flush), 64'd0);
    check("drop_F_valid", 64'(F_valid), 64'd0);
    check("drop_req", 64'(ifc.imem_req), 64'd0);
    cyc(3);

    // Cycle 16: new stream delivered.
    @(negedge clk);
    check("redir_F_valid", 64'(F_valid), 64'd1);
    check("redir_F_pc", 64'(F_pc), 64'h10);
    check("redir_F_inst", 64'(F_inst), 64'h110);
    cyc(2);

    // Cycle 18: redirect and stall together in VALID; redirect wins.
    stall_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 5'd30;
    @(negedge clk);
    check("rs_fd_en", 64'(fd_en), 64'd0);
    check("rs_fd_flush", 64'(fd_flush), 64'd1);
    check("rs_req", 64'(ifc.imem_req), 64'd0);
    cyc(1);

    // Cycle 19: FETCH at the redirect target; stream then wraps 30,31,0,1.
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    @(negedge clk);
    check("rs_F_valid", 64'(F_valid), 64'd0);
    check("rs_req_next", 64'(ifc.imem_req), 64'd1);
    check("rs_addr_next", 64'(ifc.imem_addr), 64'd30);
    cyc(9);

    // Cycle 28: WAIT; assert reset asynchronously mid-cycle.
    #2 rst_n = 1'b0;
    redirect_i = 1'b1;
    #1;
    check("async_req", 64'(ifc.imem_req), 64'd0);
    check("async_addr", 64'(ifc.imem_addr), 64'd0);
    check("async_F_valid", 64'(F_valid), 64'd0);
    check("async_F_pc", 64'(F_pc), 64'd0);
    check("async_F_inst", 64'(F_inst), 64'd0);
    check("async_fd_en", 64'(fd_en), 64'd0);
    check("async_fd_flush", 64'(fd_flush), 64'd0);
    redirect_i = 1'b0;
    cyc(2);
    rst_n = 1'b1;

    // Restart from pc=0.
    cyc(3);
    @(negedge clk);
    check("restart_F_valid", 64'(F_valid), 64'd1);
    check("restart_F_pc", 64'(F_pc), 64'd0);
    check("restart_F_inst", 64'(F_inst), 64'h100);
    cyc(2);
    @(negedge clk);
    #1;
    check("addr_queue_left", 64'(exp_addr.size()), 64'd0);
    check("fd_queue_left", 64'(exp_fd.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_ctrl
